// File: rtl/data_mem_if.sv
// data_mem_if: Ibex-style data-memory bus between a core (master) and a
// memory responder (slave).
//   master modport: drives req/addr/we/be/wdata/wdata_intg, receives
//                   gnt/rvalid/err/rdata/rdata_intg.
//   slave modport : the mirror image.
// Signal names keep their original core-relative _i/_o suffixes so that the
// responder reads exactly like the pre-interface port list.
interface data_mem_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                 data_req_i;
    logic [AddrWidth-1:0] data_addr_i;
    logic                 data_we_i;
    logic [3:0]           data_be_i;
    logic [DataWidth-1:0] data_wdata_i;
    logic [6:0]           data_wdata_intg_i;
    logic                 data_gnt_o;
    logic                 data_rvalid_o;
    logic                 data_err_o;
    logic [DataWidth-1:0] data_rdata_o;
    logic [6:0]           data_rdata_intg_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i,
               data_wdata_i, data_wdata_intg_i,
        input  data_gnt_o, data_rvalid_o, data_err_o,
               data_rdata_o, data_rdata_intg_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i,
               data_wdata_i, data_wdata_intg_i,
        output data_gnt_o, data_rvalid_o, data_err_o,
               data_rdata_o, data_rdata_intg_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: slave model of the Ibex data-memory port backed by a
// word-addressed RAM, with a configurable grant delay and a fixed response
// latency.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (RAM contents are not reset)
//   bus   : data_mem_if.slave -- req/addr/we/be/wdata/wdata_intg in,
//           gnt/rvalid/err/rdata/rdata_intg out
// Optional feature macro: DATA_MEM_RESP_INTG_EN
//   defined   : rdata_intg is the inverted SECDED(39,32) check of rdata, and a
//               write whose wdata_intg does not match is dropped with err=1.
//   undefined : rdata_intg is 0 and wdata_intg is ignored.
module data_mem_responder #(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          MemDepthWords = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr      = '0,
    parameter int unsigned          GntDelay      = 0,
    parameter int unsigned          RespLatency   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);

    localparam int unsigned          IdxWidth = $clog2(MemDepthWords);
    localparam logic [AddrWidth:0]   Span     = (AddrWidth+1)'(4 * MemDepthWords);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 gnt;
    logic                 accept;
    logic [AddrWidth:0]   diff;
    logic                 addr_err;
    logic                 intg_err;
    logic                 rsp_err;
    logic                 wr_en;
    logic [IdxWidth-1:0]  idx;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 unused_bits;

    logic [DataWidth-1:0] mem [MemDepthWords];

    logic                 pipe_valid [RespLatency];
    logic                 pipe_err   [RespLatency];
    logic [DataWidth-1:0] pipe_rdata [RespLatency];

`ifdef DATA_MEM_RESP_INTG_EN
    // Inverted SECDED(39,32) encoder; only the 7 check bits are consumed.
    function automatic logic [38:0] secded_inv_39_32_enc(input logic [31:0] d);
        logic [38:0] c;
        c     = 39'(d);
        c[32] = ^(c & 39'h002606BD25);
        c[33] = ^(c & 39'h00DEBA8050);
        c[34] = ^(c & 39'h00413D89AA);
        c[35] = ^(c & 39'h0031234ED1);
        c[36] = ^(c & 39'h00C2C1323B);
        c[37] = ^(c & 39'h002DCC624C);
        c[38] = ^(c & 39'h0098505586);
        c     = c ^ 39'h2A00000000;
        return c;
    endfunction

    logic [38:0] wdata_enc;
    logic [38:0] rdata_enc;

    assign wdata_enc = secded_inv_39_32_enc(bus.data_wdata_i);
    assign rdata_enc = secded_inv_39_32_enc(bus.data_rdata_o);
    assign intg_err  = bus.data_we_i && (bus.data_wdata_intg_i != wdata_enc[38:32]);
    assign bus.data_rdata_intg_o = rdata_enc[38:32];
    assign unused_bits = ^{diff, wdata_enc[31:0], rdata_enc[31:0]};
`else
    assign intg_err  = 1'b0;
    assign bus.data_rdata_intg_o = '0;
    assign unused_bits = ^{diff, bus.data_wdata_intg_i};
`endif

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (GntDelay == 0) begin
                    gnt = bus.data_req_i;
                end else if (bus.data_req_i) begin
                    state_d = WAIT;
                    cnt_d   = 4'(GntDelay - 1);
                end
            end
            WAIT: begin
                if (!bus.data_req_i) begin
                    // Request withdrawn before grant: abandon it entirely.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    gnt     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant is combinational from req, so it must be masked during reset.
    assign bus.data_gnt_o = gnt & rst_n;
    assign accept         = bus.data_req_i & bus.data_gnt_o;

    // ------------------------------------------------------------------
    // Address decode: one extra bit catches addresses below BaseAddr as a
    // borrow, so no comparison against a possibly-zero constant is needed.
    // ------------------------------------------------------------------
    assign diff     = {1'b0, bus.data_addr_i} - {1'b0, BaseAddr};
    assign addr_err = diff[AddrWidth] || ({1'b0, diff[AddrWidth-1:0]} >= Span);
    assign idx      = diff[IdxWidth+1:2];
    assign rsp_err  = addr_err | intg_err;
    assign wr_en    = accept & bus.data_we_i & ~rsp_err;

    // Read sees the RAM before this edge's update; writes answer with 0.
    assign rsp_rdata = (bus.data_we_i || rsp_err) ? '0 : mem[idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < DataWidth / 8; i++) begin
                if (bus.data_be_i[i]) begin
                    mem[idx][8*i +: 8] <= bus.data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response delay line; idle stages carry zeros so err/rdata stay 0
    // whenever rvalid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RespLatency; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_rdata[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept & rsp_err;
            pipe_rdata[0] <= accept ? rsp_rdata : '0;
            for (int unsigned i = 1; i < RespLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
        end
    end

    assign bus.data_rvalid_o = pipe_valid[RespLatency-1];
    assign bus.data_err_o    = pipe_err[RespLatency-1];
    assign bus.data_rdata_o  = pipe_rdata[RespLatency-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Three configurations run side by side:
//   d0: GntDelay=0, RespLatency=1, base 0x0,          1024 words
//   d1: GntDelay=3, RespLatency=4, base 0x0,          1024 words
//   d2: GntDelay=0, RespLatency=4, base 0x8000_0000,  256 words
// A reference model (byte-updated word array plus expected-response queues
// stamped with their due cycle) predicts every response.
module tb_data_mem_responder;

    localparam int ND = 3;

    function automatic int gd_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction
    function automatic int rl_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction
    function automatic longint base_of(input int d);
        return (d == 2) ? 64'h8000_0000 : 64'h0;
    endfunction
    function automatic int depth_of(input int d);
        return (d == 2) ? 256 : 1024;
    endfunction

`ifdef DATA_MEM_RESP_INTG_EN
    function automatic logic [6:0] enc7(input logic [31:0] d);
        logic [38:0] c;
        c     = 39'(d);
        c[32] = ^(c & 39'h002606BD25);
        c[33] = ^(c & 39'h00DEBA8050);
        c[34] = ^(c & 39'h00413D89AA);
        c[35] = ^(c & 39'h0031234ED1);
        c[36] = ^(c & 39'h00C2C1323B);
        c[37] = ^(c & 39'h002DCC624C);
        c[38] = ^(c & 39'h0098505586);
        c     = c ^ 39'h2A00000000;
        return c[38:32];
    endfunction
    function automatic logic [6:0] intg_exp(input logic [31:0] d);
        return enc7(d);
    endfunction
    function automatic logic [6:0] intg_drv(input logic [31:0] d);
        return enc7(d);
    endfunction
`else
    function automatic logic [6:0] intg_exp(input logic [31:0] d);
        return (d == d) ? 7'h00 : 7'h7F;
    endfunction
    function automatic logic [6:0] intg_drv(input logic [31:0] d);
        return 7'($urandom) ^ 7'(d);
    endfunction
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a [ND];
    logic        we_a  [ND];
    logic [31:0] addr_a[ND];
    logic [3:0]  be_a  [ND];
    logic [31:0] wd_a  [ND];
    logic [6:0]  wi_a  [ND];
    logic        gnt_a [ND];
    logic        rv_a  [ND];
    logic        err_a [ND];
    logic [31:0] rd_a  [ND];
    logic [6:0]  ri_a  [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        data_mem_if #(.AddrWidth(32), .DataWidth(32)) bus ();

        data_mem_responder #(
            .AddrWidth    (32),
            .DataWidth    (32),
            .MemDepthWords(depth_of(g)),
            .BaseAddr     (32'(base_of(g))),
            .GntDelay     (gd_of(g)),
            .RespLatency  (rl_of(g))
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        assign bus.data_req_i        = req_a[g];
        assign bus.data_we_i         = we_a[g];
        assign bus.data_addr_i       = addr_a[g];
        assign bus.data_be_i         = be_a[g];
        assign bus.data_wdata_i      = wd_a[g];
        assign bus.data_wdata_intg_i = wi_a[g];
        assign gnt_a[g] = bus.data_gnt_o;
        assign rv_a[g]  = bus.data_rvalid_o;
        assign err_a[g] = bus.data_err_o;
        assign rd_a[g]  = bus.data_rdata_o;
        assign ri_a[g]  = bus.data_rdata_intg_o;
    end

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        exp_q [ND][$];
    logic [31:0] ref_mem [longint];
    logic [31:0] ws [ND][8];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    // Reference behaviour of one accepted request.
    task automatic model_accept(input int d);
        rsp_t        r;
        longint      a, b, key;
        logic [31:0] w;
        a       = longint'(addr_a[d]);
        b       = base_of(d);
        r.due   = cyc + rl_of(d);
        r.err   = (a < b) || (a >= b + 4 * depth_of(d));
        r.rdata = '0;
`ifdef DATA_MEM_RESP_INTG_EN
        if (we_a[d] && (wi_a[d] !== enc7(wd_a[d]))) r.err = 1'b1;
`endif
        if (!r.err) begin
            key = longint'(d) * 64'h1_0000_0000 + ((a - b) >> 2);
            w   = ref_mem.exists(key) ? ref_mem[key] : 32'hx;
            if (we_a[d]) begin
                for (int i = 0; i < 4; i++)
                    if (be_a[d][i]) w[8*i +: 8] = wd_a[d][8*i +: 8];
                ref_mem[key] = w;
            end else begin
                r.rdata = w;
            end
        end
        exp_q[d].push_back(r);
    endtask

    // Response / reset checker, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            rsp_t        h;
            logic [31:0] exp_rd;
            exp_rd = '0;
            if (!rst_n) begin
                exp_q[d].delete();
                chk("rst_gnt",    64'(gnt_a[d]), 64'(0));
                chk("rst_rvalid", 64'(rv_a[d]),  64'(0));
                chk("rst_err",    64'(err_a[d]), 64'(0));
                chk("rst_rdata",  64'(rd_a[d]),  64'(0));
                chk("rst_intg",   64'(ri_a[d]),  64'(intg_exp(32'h0)));
            end else begin
                if (rv_a[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk("unexpected_rvalid", 64'(rv_a[d]), 64'(0));
                    end else begin
                        h = exp_q[d].pop_front();
                        chk("rvalid_cycle", 64'(cyc),      64'(h.due));
                        chk("rsp_err",      64'(err_a[d]), 64'(h.err));
                        chk("rsp_rdata",    64'(rd_a[d]),  64'(h.rdata));
                        exp_rd = h.rdata;
                    end
                end else begin
                    chk("idle_err",   64'(err_a[d]), 64'(0));
                    chk("idle_rdata", 64'(rd_a[d]),  64'(0));
                    if (exp_q[d].size() != 0 && exp_q[d][0].due <= cyc) begin
                        chk("rvalid_missing", 64'(rv_a[d]), 64'(1));
                        exp_q[d].delete(0);
                    end
                end
                chk("rdata_intg", 64'(ri_a[d]), 64'(intg_exp(exp_rd)));
                if (!req_a[d]) chk("gnt_without_req", 64'(gnt_a[d]), 64'(0));
                if (req_a[d] && gnt_a[d]) model_accept(d);
            end
        end
    end

    // One request; entered and left at posedge+1.
    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input logic corrupt);
        int waited;
        bit got;
        waited    = 0;
        got       = 0;
        req_a[d]  = 1'b1;
        we_a[d]   = we;
        addr_a[d] = addr;
        be_a[d]   = be;
        wd_a[d]   = wd;
        wi_a[d]   = intg_drv(wd) ^ (corrupt ? 7'h01 : 7'h00);
        while (!got && waited <= 20) begin
            @(negedge clk);
            if (gnt_a[d]) got = 1;
            else waited++;
        end
        chk("gnt_delay", got ? 64'(waited) : 64'hFFFF, 64'(gd_of(d)));
        @(posedge clk); #1;
        req_a[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          gcount;
        int          d;
        int          k;
        logic [31:0] a;
        logic [31:0] b2;

        rst_n = 1'b0;
        for (int i = 0; i < ND; i++) begin
            req_a[i] = 0; we_a[i] = 0; addr_a[i] = '0;
            be_a[i] = '0; wd_a[i] = '0; wi_a[i] = '0;
        end
        req_a[0] = 1'b1;                 // grant must stay low under reset
        repeat (3) @(posedge clk);
        #1;
        req_a[0] = 1'b0;
        rst_n    = 1'b1;
        idle(1);

        // Full write then read, partial write merge, read-after-write
        access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
        access(0, 0, 32'h10, 4'hF, $urandom, 0);
        access(0, 1, 32'h20, 4'hF, 32'hDEADBEEF, 0);
        access(0, 1, 32'h20, 4'b0101, 32'h11223344, 0);
        access(0, 0, 32'h20, 4'hF, 32'h0, 0);

        // Range boundaries; out-of-range write must not alias word 0
        access(0, 1, 32'h0,    4'hF, 32'hCAFE0000, 0);
        access(0, 1, 32'h0FFC, 4'hF, 32'h0BADF00D, 0);
        access(0, 1, 32'h1000, 4'hF, 32'h55555555, 0);
        access(0, 0, 32'h1000, 4'hF, 32'h0, 0);
        access(0, 0, 32'h0FFC, 4'hF, 32'h0, 0);
        access(0, 0, 32'h0,    4'hF, 32'h0, 0);
        access(0, 0, 32'h0FFF, 4'hF, 32'h0, 0);

        // Delayed grant, back-to-back ordering
        access(1, 1, 32'h40, 4'hF, 32'h01020304, 0);
        access(1, 1, 32'h44, 4'hF, 32'hA0B0C0D0, 0);
        access(1, 0, 32'h40, 4'hF, 32'h0, 0);
        access(1, 0, 32'h44, 4'hF, 32'h0, 0);

        // Request withdrawn in WAIT: no grant, next request sees full delay
        gcount    = 0;
        req_a[1]  = 1'b1;
        we_a[1]   = 1'b0;
        addr_a[1] = 32'h40;
        repeat (2) begin
            @(negedge clk); if (gnt_a[1]) gcount++;
            @(posedge clk); #1;
        end
        req_a[1] = 1'b0;
        repeat (4) begin
            @(negedge clk); if (gnt_a[1]) gcount++;
            @(posedge clk); #1;
        end
        chk("drop_no_gnt", 64'(gcount), 64'(0));
        access(1, 0, 32'h40, 4'hF, 32'h0, 0);

        // Non-zero base, smaller depth
        b2 = 32'h8000_0000;
        access(2, 1, b2,           4'hF, 32'h13579BDF, 0);
        access(2, 1, b2 + 32'h3FC, 4'hF, 32'h2468ACE0, 0);
        access(2, 1, b2 - 32'h4,   4'hF, 32'hFFFFFFFF, 0);
        access(2, 1, b2 + 32'h400, 4'hF, 32'hEEEEEEEE, 0);
        access(2, 0, b2,           4'hF, 32'h0, 0);
        access(2, 0, b2 + 32'h3FC, 4'hF, 32'h0, 0);
        access(2, 0, b2 - 32'h4,   4'hF, 32'h0, 0);
        idle(6);

        // Randomised traffic over a fully initialised working set
        for (int i = 0; i < ND; i++) begin
            for (int j = 0; j < 8; j++)
                ws[i][j] = 32'(base_of(i)) + 32'(4 * $urandom_range(0, depth_of(i) - 1));
            ws[i][0] = 32'(base_of(i));
            ws[i][7] = 32'(base_of(i)) + 32'(4 * (depth_of(i) - 1));
            for (int j = 0; j < 8; j++) access(i, 1, ws[i][j], 4'hF, $urandom, 0);
        end
        for (int n = 0; n < 150; n++) begin
            d = $urandom_range(0, ND - 1);
            k = $urandom_range(0, 7);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    a = 32'(base_of(d)) + 32'(4 * depth_of(d)) + 32'(4 * k);
                else
                    a = 32'(base_of(d)) - 32'(4 * (k + 1));
            end else begin
                a = ws[d][k];
            end
            a = a | 32'($urandom_range(0, 3));
            access(d, 1'($urandom), a, 4'($urandom), $urandom, 0);
        end
        idle(6);

        // Reset with two responses in flight: both lost, RAM kept
        access(2, 1, b2 + 32'h40, 4'hF, 32'hA5A50001, 0);
        access(2, 1, b2 + 32'h44, 4'hF, 32'hA5A50002, 0);
        rst_n = 1'b0;
        idle(2);
        rst_n  = 1'b1;
        gcount = 0;
        repeat (8) begin
            @(negedge clk); if (rv_a[2]) gcount++;
            @(posedge clk); #1;
        end
        chk("flush_no_rvalid", 64'(gcount), 64'(0));
        access(2, 0, b2 + 32'h40, 4'hF, 32'h0, 0);
        access(2, 0, b2 + 32'h44, 4'hF, 32'h0, 0);
        access(0, 0, 32'h20, 4'hF, 32'h0, 0);

`ifdef DATA_MEM_RESP_INTG_EN
        // Corrupted write integrity: rejected, word keeps its old value
        access(0, 1, 32'h30, 4'hF, 32'h0, 0);
        access(0, 1, 32'h30, 4'hF, 32'h12345678, 1);
        access(0, 0, 32'h30, 4'hF, 32'h0, 0);
`endif

        idle(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Synthesizable slave model of the Ibex data-memory port. It sits directly downstream of the core's data bus, consuming `data_req/addr/we/be/wdata` and producing `data_gnt/rvalid/rdata/err`. It backs a word-addressed RAM with a configurable grant delay and a fixed response latency. It is the RTL counterpart the memory monitor observes in the standalone core bench.

## Interface
- `AddrWidth`, 32: request address width.
- `DataWidth`, 32: data width; must be 32.
- `MemDepthWords`, 1024: RAM depth in 32-bit words; power of two.
- `BaseAddr`, 32'h0000_0000: byte address of word 0; aligned to `4*MemDepthWords`.
- `GntDelay`, 0: cycles `data_req_i` must be held before `data_gnt_o`; legal range 0..15.
- `RespLatency`, 1: cycles from the grant edge to `data_rvalid_o`; legal range 1..8.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `data_req_i` input 1: request valid.
- `data_addr_i` input AddrWidth: byte address; bits [1:0] ignored.
- `data_we_i` input 1: 1 = write.
- `data_be_i` input 4: byte enables.
- `data_wdata_i` input 32: write data.
- `data_wdata_intg_i` input 7: write-data integrity.
- `data_gnt_o` output 1: request accepted this cycle.
- `data_rvalid_o` output 1: response valid.
- `data_err_o` output 1: response error; qualified by rvalid.
- `data_rdata_o` output 32: read data; qualified by rvalid.
- `data_rdata_intg_o` output 7: read-data integrity.

## Operation
- Grant FSM has two states, IDLE and WAIT.
  - IDLE, `GntDelay==0`: `data_gnt_o = data_req_i`.
  - IDLE, `GntDelay>0`: on `req`, move to WAIT and load the counter with `GntDelay-1`.
  - WAIT: the counter decrements each cycle. `gnt` is asserted combinationally in the cycle where the counter is 0 and `req` is high. The FSM returns to IDLE after the grant edge.
  - If `req` drops in WAIT (protocol violation), the FSM returns to IDLE, clears the counter and grants nothing.
- Back-to-back requests with `GntDelay>0` each incur the full delay.
- Acceptance is the rising edge where `req && gnt`. At that edge:
  - Range check: `err = (addr < BaseAddr) || (addr >= BaseAddr + 4*MemDepthWords)`. The index is `(addr-BaseAddr)>>2`, truncated to `log2(MemDepthWords)` bits.
  - Write with no error: each byte lane `i` with `be[i]=1` is updated. A write response carries `rdata = 0`.
  - Read with no error: the word is captured from the RAM state before this edge's write (only one access per edge, so there is no conflict).
  - Error: no RAM update, `rdata = 0`, `err = 1`.
- Response path: a delay line of `RespLatency` stages carries `{valid, err, rdata}`. There is no back-pressure, since Ibex always accepts `rvalid`. Responses are returned in order, at most one per cycle.
- The RAM is not reset; its contents are undefined until written, or until preloaded via `$readmemh` in simulation.

## Timing
- With the grant at edge E, `data_rvalid_o` is high during the cycle following edge `E + RespLatency - 1`. For `RespLatency=1`, rvalid is high in the cycle directly after the grant cycle.
- `data_rvalid_o` is high for exactly one cycle per grant.
- A read granted at the edge after a write to the same word returns the new data.
- Reset values: `data_gnt_o` is 0 (forced low while `rst_n` is low), `data_rvalid_o` 0, `data_err_o` 0, `data_rdata_o` 0, and `data_rdata_intg_o` equals the encoding of 0 (or 0 when integrity is compiled out). FSM resets to IDLE.
- Reset mid-operation flushes the delay line; in-flight responses are lost. RAM contents are retained.
- `data_err_o` and `data_rdata_o` are 0 whenever `data_rvalid_o` is 0.

## Configuration
- `DATA_MEM_RESP_INTG_EN` defined:
  - `data_rdata_intg_o` is the output of `prim_secded_inv_39_32_enc` applied to `data_rdata_o`.
  - On a write, `data_wdata_intg_i` is checked against the encoding of `data_wdata_i`. A mismatch suppresses the write and returns `err=1`.
- Not defined: `data_rdata_intg_o` is tied to 0, and `data_wdata_intg_i` is ignored.

## Test plan
- Reset release, then write 0xDEADBEEF to 0x10 (`be=4'hF`, GntDelay=0, RespLatency=1) -> gnt in the same cycle, rvalid next cycle with err=0. A read of 0x10 then returns 0xDEADBEEF.
- Partial write: `be=4'b0101`, wdata 0x11223344, over 0xDEADBEEF at 0x20 -> a read of 0x20 returns 0xDE22BE44.
- GntDelay=3, RespLatency=4: hold req -> gnt after exactly 3 cycles, and rvalid 4 cycles after the grant edge. Requests granted back-to-back return in order.
- Address `BaseAddr + 4*MemDepthWords` (0x1000) -> err=1, rdata=0, RAM unchanged. Address 0x0FFC -> err=0.
- Drop req in WAIT -> no gnt, FSM returns to IDLE. Assert `rst_n=0` with two responses in flight -> no rvalid after release, and earlier-written data is still readable.
- With `DATA_MEM_RESP_INTG_EN`, a write with a corrupted `wdata_intg` -> err=1, no update. A read of 0 returns `rdata_intg` equal to the encoder's output for 0.
